// File: rtl/mult_seq_assembler.sv
// Sequencer/accumulator for the nibble-serial 8x8 multiplier: walks sel through the four
// nibble pairs, shift-adds each 2N-bit partial product into a 4N-bit result, pulses done.
module mult_seq_assembler #(
    parameter int NIBBLE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2*NIBBLE_W-1:0] pp,
    output logic [1:0]            sel,
    output logic [4*NIBBLE_W-1:0] product,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = 4 * NIBBLE_W;

    // Encoding puts the nibble-select code in the low bits of the S-states and
    // uses bit 2 to mark the non-busy states, so sel/busy decode straight from state.
    typedef enum logic [2:0] {
        S00  = 3'b000,
        S01  = 3'b001,
        S10  = 3'b010,
        S11  = 3'b011,
        IDLE = 3'b100,
        FIN  = 3'b101
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   product_q, product_d;
    logic [PW-1:0]   pp_ext;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        pp_ext    = PW'(pp);
        case (state_q)
            IDLE: begin
                if (start) begin
                    product_d = '0;
                    state_d   = S00;
                end
            end
            S00: begin
                product_d = product_q + pp_ext;
                state_d   = S01;
            end
            S01: begin
                product_d = product_q + (pp_ext << NIBBLE_W);
                state_d   = S10;
            end
            S10: begin
                product_d = product_q + (pp_ext << NIBBLE_W);
                state_d   = S11;
            end
            S11: begin
                product_d = product_q + (pp_ext << (2 * NIBBLE_W));
                state_d   = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel     = state_q[2] ? 2'b00 : state_q[1:0];
    assign busy    = ~state_q[2];
    assign done    = (state_q == FIN);
    assign product = product_q;

endmodule

// File: tb/tb_mult_seq_assembler.sv
// Bench for mult_seq_assembler: models mux4 + 4x4 multiplier to close the pp loop.
// Checks product against plain dataa*datab along with sel/busy/done timing.
// Drives start directly; the DUT has no backpressure beyond ignoring start while busy.
module tb_mult_seq_assembler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  pp;
    logic [1:0]  sel;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic [7:0]  dataa, datab;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_seq_assembler #(.NIBBLE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .pp      (pp),
        .sel     (sel),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [7:0] nib_mul(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] an, bn;
        an = s[0] ? a[7:4] : a[3:0];
        bn = s[1] ? b[7:4] : b[3:0];
        return 8'(an) * 8'(bn);
    endfunction

    assign pp = nib_mul(sel, dataa, datab);

    task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [15:0] exp_p;
        int          busy_cnt;
        int          done_at;
        exp_p    = 16'(a) * 16'(b);
        dataa    = a;
        datab    = b;
        start    = 1'b1;
        busy_cnt = 0;
        done_at  = 0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) begin
                tests++;
                if (sel !== 2'(busy_cnt)) begin
                    fails++;
                    $error("FAIL %s/sel: observed %0h, expected %0h", tag, sel, 2'(busy_cnt));
                end
                busy_cnt++;
            end
            if (done) begin
                done_at = k;
                break;
            end
        end
        tests++;
        if (done_at !== 5) begin
            fails++;
            $error("FAIL %s/done_at: observed %0d, expected 5", tag, done_at);
        end
        tests++;
        if (busy_cnt !== 4) begin
            fails++;
            $error("FAIL %s/busy_cycles: observed %0d, expected 4", tag, busy_cnt);
        end
        tests++;
        if (product !== exp_p) begin
            fails++;
            $error("FAIL %s/product: observed %0h, expected %0h", tag, product, exp_p);
        end
        @(negedge clk);
        tests++;
        if ({done, busy, sel} !== 4'b0000) begin
            fails++;
            $error("FAIL %s/after_done: observed %0h, expected 0", tag, {done, busy, sel});
        end
        tests++;
        if (product !== exp_p) begin
            fails++;
            $error("FAIL %s/product_hold: observed %0h, expected %0h", tag, product, exp_p);
        end
    endtask

    initial begin
        int          done_cnt;
        int          last_done;
        int          seen_done;
        logic [7:0]  ra, rb;

        reset_n = 1'b0;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (product !== 16'h0000) begin
            fails++;
            $error("FAIL reset/product: observed %0h, expected 0", product);
        end
        tests++;
        if ({done, busy, sel} !== 4'b0000) begin
            fails++;
            $error("FAIL reset/ctrl: observed %0h, expected 0", {done, busy, sel});
        end
        reset_n = 1'b1;
        @(negedge clk);

        do_mult(8'hF0, 8'hA5, "f0xa5");
        tests++;
        if (product !== 16'h9AB0) begin
            fails++;
            $error("FAIL f0xa5/value: observed %0h, expected 9ab0", product);
        end
        do_mult(8'hFF, 8'hFF, "ffxff");
        tests++;
        if (product !== 16'hFE01) begin
            fails++;
            $error("FAIL ffxff/value: observed %0h, expected fe01", product);
        end
        do_mult(8'h00, 8'hC3, "00xc3");
        tests++;
        if (product !== 16'h0000) begin
            fails++;
            $error("FAIL 00xc3/value: observed %0h, expected 0", product);
        end

        dataa     = 8'h12;
        datab     = 8'h34;
        start     = 1'b1;
        done_cnt  = 0;
        last_done = 0;
        for (int k = 1; k <= 40 && done_cnt < 3; k++) begin
            @(negedge clk);
            if (done) begin
                tests++;
                if (product !== 16'h03A8) begin
                    fails++;
                    $error("FAIL b2b/product: observed %0h, expected 3a8", product);
                end
                if (done_cnt == 0) begin
                    tests++;
                    if (k !== 5) begin
                        fails++;
                        $error("FAIL b2b/first_done: observed %0d, expected 5", k);
                    end
                end else begin
                    tests++;
                    if (k - last_done !== 6) begin
                        fails++;
                        $error("FAIL b2b/spacing: observed %0d, expected 6", k - last_done);
                    end
                end
                last_done = k;
                done_cnt++;
            end
        end
        tests++;
        if (done_cnt !== 3) begin
            fails++;
            $error("FAIL b2b/done_count: observed %0d, expected 3", done_cnt);
        end
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({done, busy, sel} !== 4'b0000) begin
            fails++;
            $error("FAIL b2b/idle: observed %0h, expected 0", {done, busy, sel});
        end

        dataa = 8'hF0;
        datab = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, sel} !== 3'b101) begin
            fails++;
            $error("FAIL abort/in_s01: observed %0h, expected 5", {busy, sel});
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tests++;
        if (product !== 16'h0000) begin
            fails++;
            $error("FAIL abort/product: observed %0h, expected 0", product);
        end
        tests++;
        if ({done, busy, sel} !== 4'b0000) begin
            fails++;
            $error("FAIL abort/ctrl: observed %0h, expected 0", {done, busy, sel});
        end
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            seen_done += int'(done) + int'(busy);
        end
        tests++;
        if (seen_done !== 0) begin
            fails++;
            $error("FAIL abort/no_done: observed %0d, expected 0", seen_done);
        end
        do_mult(8'hF0, 8'hA5, "post_abort");

        do_mult(8'h0F, 8'h0F, "0fx0f");
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (product !== 16'h00E1 || done !== 1'b0 || sel !== 2'b00) seen_done++;
        end
        tests++;
        if (seen_done !== 0) begin
            fails++;
            $error("FAIL idle_hold/violations: observed %0d, expected 0", seen_done);
        end
        tests++;
        if (product !== 16'h00E1) begin
            fails++;
            $error("FAIL idle_hold/product: observed %0h, expected e1", product);
        end

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_mult(ra, rb, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
